uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter for the RS-232 link; the counterpart of the board's UART receive path (8N1, LSB first, idle-high line).
- Takes bytes from the command/control logic over a valid/ready handshake and serialises them on rs232_tx.
- Has its own baud-tick generator, so no external clk_bps/bps_start pair is needed. Sits next to the receiver in the UART top.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz
- BAUD, 115200, line rate in bit/s
- CLKS_PER_BIT, (CLK_FREQ+BAUD/2)/BAUD, derived (rounded) clocks per bit; must be >= 2 (elaboration error otherwise)

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rstn  input  1  asynchronous active-low reset; deassertion is synchronous to sys_clk upstream
- tx_data  input  8  byte to send; sampled only on the accept edge
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a byte (IDLE only)
- rs232_tx  output  1  serial line, registered output
- tx_busy  output  1  frame in progress (any state other than IDLE)
- tx_done  output  1  one-cycle pulse when the stop bit finishes

Behaviour:
- Reset values: rs232_tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0.
- Handshake: a byte is accepted on a rising edge where tx_valid&&tx_ready. tx_data is captured into a shift register on that edge. tx_valid while not ready is ignored, and no data is lost internally: the source holds it.
- FSM states: IDLE, START, DATA, STOP (PARITY added with the optional feature).
- IDLE -> START on accept. On the same edge rs232_tx<=0, tx_ready<=0, tx_busy<=1, and the baud counter clears.
- Every state except IDLE lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, and the state advances on the terminal count.
- START -> DATA: rs232_tx<=shift[0].
- DATA: 8 bits, LSB first, bit counter 0..7. After bit 7 go to STOP with rs232_tx<=1.
- STOP -> IDLE. On that edge tx_ready<=1, tx_busy<=0, tx_done<=1 for one cycle; rs232_tx stays 1.
- Frame length: start-bit falling edge to end of stop bit = 10*CLKS_PER_BIT cycles exactly.
- Back-to-back: with tx_valid held high, the next accept happens one cycle after returning to IDLE. This gives exactly 1 idle-high clock between frames.
- Mid-frame reset: all state returns to reset values immediately and asynchronously; the line goes high. A partial frame is dropped, not resumed.
- tx_data changes after accept have no effect on the frame in flight.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit counter is 3 bits. No wrap beyond those ranges.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP, lasting one bit time. It sends even parity: XOR of the 8 data bits, so that data plus parity has an even count of ones. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no parity state or logic; 8N1 only.

Decomposition:
- Package uart_pkg: the FSM state enum typedef (tx_state_t) and the CLKS_PER_BIT computation function. The same package is shared with the receive side.
- Sub-module uart_baud_gen: a counter with clear and enable inputs that outputs a terminal-count tick. It is reusable by a later mid-bit-sampling receiver.

Test Plan:
- Use CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10) unless stated.
- Reset: hold sys_rstn=0 -> rs232_tx=1, tx_ready=1, tx_busy=0, tx_done=0.
- Send 0x55 -> line is low 10 clk, then bits 1,0,1,0,1,0,1,0 at 10 clk each, then high 10 clk. tx_done pulses once at cycle 100 after accept; tx_ready returns high on that same edge.
- tx_valid held high with 0xA3 then 0x0F -> both frames are correct, with exactly 1 idle-high clock between the stop bit and the next start bit.
- tx_valid pulsed while busy with 0xFF -> ignored; the current frame is unchanged and no extra frame is sent.
- Reset asserted at cycle 45 of a frame -> line high immediately and tx_ready=1 after release. A following 0x81 sends a clean, complete frame.
- UART_TX_PARITY_EN, send 0x07 -> parity bit=1 and the frame is 110 clk. With 0x03 -> parity bit=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: UART types and baud helpers shared by the transmit and receive sides.
// UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter that ticks on its terminal count.
// clr restarts the period; the counter only advances while en is high.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic sys_clk,
  input  logic sys_rstn,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
  end
  assign tick = en && cnt == LAST;
  always_ff @(posedge sys_clk or negedge sys_rstn)
    if (!sys_rstn) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, 8N1 LSB-first serial out on rs232_tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  tx_state_t  state;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       tick;
  logic       accept;
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  assign accept = tx_valid && tx_ready;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .sys_clk (sys_clk),
    .sys_rstn(sys_rstn),
    .clr     (accept),
    .en      (tx_busy),
    .tick    (tick)
  );
  // shift rotates once per data bit, so after bit 7 it holds the original byte again
  always_ff @(posedge sys_clk or negedge sys_rstn)
    if (!sys_rstn) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      rs232_tx <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            state    <= START;
            shift    <= tx_data;
            bit_cnt  <= '0;
            rs232_tx <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        START:
          if (tick) begin
            state    <= DATA;
            rs232_tx <= shift[0];
          end
        DATA:
          if (tick) begin
            shift   <= {shift[0], shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              rs232_tx <= ^shift;
`else
              state    <= STOP;
              rs232_tx <= 1'b1;
`endif
            end else
              rs232_tx <= shift[1];
          end
`ifdef UART_TX_PARITY_EN
        PARITY:
          if (tick) begin
            state    <= STOP;
            rs232_tx <= 1'b1;
          end
`endif
        STOP:
          if (tick) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx cycle by cycle against a queue-based line model.
// Build with UART_TX_PARITY_EN to check the 11-bit parity frame instead.
module tb_uart_tx;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;
  logic       sys_clk  = 1'b0;
  logic       sys_rstn = 1'b0;
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rs232_tx, tx_busy, tx_done;
  int n_chk = 0, n_pass = 0, done_seen = 0;
  bit q[$];
  bit busy_m = 0, line_m = 1, done_m = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .sys_clk (sys_clk),
    .sys_rstn(sys_rstn),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rs232_tx(rs232_tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // expected line level for every clock of one frame, start bit first
  task automatic push_frame(input logic [7:0] d);
    logic [NB-1:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^d, d, 1'b0};
`else
    f = {1'b1, d, 1'b0};
`endif
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < CPB; j++) q.push_back(f[i]);
  endtask

  task automatic model_reset();
    q.delete();
    busy_m = 0;
    line_m = 1;
    done_m = 0;
  endtask

  task automatic verify();
    check("line", rs232_tx, line_m);
    check("ready", tx_ready, !busy_m);
    check("busy", tx_busy, busy_m);
    check("done", tx_done, done_m);
  endtask

  task automatic step();
    @(posedge sys_clk);
    if (!sys_rstn) model_reset();
    else begin
      if (tx_valid && !busy_m) begin
        push_frame(tx_data);
        busy_m = 1;
      end
      done_m = 0;
      line_m = 1;
      if (q.size() > 0) line_m = q.pop_front();
      else if (busy_m) begin
        busy_m = 0;
        done_m = 1;
      end
    end
    @(negedge sys_clk);
    if (tx_done) done_seen++;
    verify();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!tx_done && n < 200) begin
      step();
      n++;
    end
    check(tag, 16'(n), 16'(FL));
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = ~d;
    wait_done("done_cyc");
    step();
  endtask

  initial begin
    int d0;
    repeat (3) step();
    sys_rstn = 1'b1;
    step();
    send(8'h55);
    // held valid: second byte must start after exactly one idle clock
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h0F;
    wait_done("b2b_first");
    step();
    check("b2b_start", rs232_tx, 1'b0);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_done("b2b_second");
    step();
    // a byte offered mid-frame is ignored
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (30) step();
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    d0 = done_seen;
    for (int i = 0; i < 200 && tx_busy; i++) step();
    repeat (20) step();
    check("no_extra", 16'(done_seen - d0), 16'd1);
    // reset 45 clocks into a frame
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (45) step();
    sys_rstn = 1'b0;
    #1;
    model_reset();
    verify();
    repeat (2) step();
    sys_rstn = 1'b1;
    step();
    check("ready_after_rst", tx_ready, 1'b1);
    send(8'h81);
    send(8'h07);
    send(8'h03);
    // random traffic: valid on ~3/4 of cycles, data changing every clock
    repeat (600) begin
      tx_valid = ($urandom % 4) != 0;
      tx_data  = 8'($urandom);
      step();
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 200 && busy_m; i++) step();
    repeat (3) step();
    check("idle_end", tx_busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
